// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM frame arbiter.
package vram_arb_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned FRAME_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wr_fifo.sv
// Synchronous FIFO of buffered game tile writes ({addr, data}).
module wr_fifo #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_pop,
  output logic [ADDR_W-1:0]      o_head_addr_c,
  output logic [DATA_W-1:0]      o_head_data_c,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok, pop_ok;

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    o_full_c  = (count_q == CNT_W'(DEPTH));
    o_empty_c = (count_q == '0);
    push_ok   = i_push && !o_full_c;
    pop_ok    = i_pop && !o_empty_c;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {i_addr, i_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign {o_head_addr_c, o_head_data_c} = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/vram_frame_arbiter.sv
// Tile-map RAM arbiter: renderer reads win; game writes are queued and
// committed only during vertical blank so the displayed frame never tears.
module vram_frame_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_animate,
  input  logic              i_screenend,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_drain_done,
  output logic              o_late,
  output logic [7:0]        o_frame_cnt
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_e             state_q, state_d;
  logic                   fifo_full, fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  logic [ADDR_W-1:0]      head_addr;
  logic [DATA_W-1:0]      head_data;
  logic                   push_c, rd_gnt_c, wr_gnt_c, empty_after_c;
  logic                   rd_valid_q, rd_valid_d;
  logic                   drain_done_q, drain_done_d;
  logic                   late_q, late_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign push_c = i_wr_valid && !fifo_full;

  wr_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_wr_fifo (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_push        (push_c),
    .i_addr        (i_wr_addr),
    .i_data        (i_wr_data),
    .i_pop         (wr_gnt_c),
    .o_head_addr_c (head_addr),
    .o_head_data_c (head_data),
    .o_full_c      (fifo_full),
    .o_empty_c     (fifo_empty),
    .o_count       (fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  // End of active video beats animate; only screenend closes the blank.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SCAN: begin
        if (i_animate && !i_screenend) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_screenend)        state_d = ST_SCAN;
        else if (empty_after_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (i_screenend) state_d = ST_SCAN;
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Grant mux plus next values of the registered status outputs.
  always_comb begin
    rd_gnt_c      = i_rd_req;
    wr_gnt_c      = 1'b0;
    o_mem_en      = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    drain_done_d  = 1'b0;
    late_d        = 1'b0;
    if (!rd_gnt_c && (state_q != ST_SCAN) && !fifo_empty) begin
      wr_gnt_c = 1'b1;
    end
    if (rd_gnt_c) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_rd_addr;
    end else if (wr_gnt_c) begin
      o_mem_en    = 1'b1;
      o_mem_we    = 1'b1;
      o_mem_addr  = head_addr;
      o_mem_wdata = head_data;
    end
    // Looks through this cycle's pop so done lands right after the last write.
    empty_after_c = (fifo_count == '0) ||
                    ((fifo_count == CNT_W'(1)) && wr_gnt_c && !push_c);
    if (state_q == ST_DRAIN) begin
      drain_done_d = !i_screenend && empty_after_c;
      late_d       = i_screenend && !empty_after_c;
    end
    rd_valid_d  = rd_gnt_c;
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(i_screenend);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q   <= 1'b0;
      drain_done_q <= 1'b0;
      late_q       <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      rd_valid_q   <= rd_valid_d;
      drain_done_q <= drain_done_d;
      late_q       <= late_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign o_rd_valid   = rd_valid_q;
  assign o_rd_data    = i_mem_rdata;
  assign o_wr_ready   = !fifo_full;
  assign o_drain_done = drain_done_q;
  assign o_late       = late_q;
  assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vram_frame_arbiter.sv
// Directed self-checking bench for vram_frame_arbiter with a 1-cycle RAM model.
module tb_vram_frame_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 4;

  logic          i_clk, i_rst_n;
  logic          i_animate, i_screenend;
  logic          i_rd_req;
  logic [AW-1:0] i_rd_addr;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_wr_valid;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_ready;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;
  logic          o_drain_done, o_late;
  logic [7:0]    o_frame_cnt;

  int n_tests;
  int n_fail;

  vram_frame_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_animate    (i_animate),
    .i_screenend  (i_screenend),
    .i_rd_req     (i_rd_req),
    .i_rd_addr    (i_rd_addr),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .i_wr_valid   (i_wr_valid),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .o_wr_ready   (o_wr_ready),
    .o_mem_en     (o_mem_en),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata),
    .o_drain_done (o_drain_done),
    .o_late       (o_late),
    .o_frame_cnt  (o_frame_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Tile RAM model: preset to ram[i] = i, one-cycle read latency.
  logic [DW-1:0] ram [32];
  logic [DW-1:0] ram_rdata;
  logic          ram_clr;
  always @(posedge i_clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32; i++) ram[i] <= DW'(i);
      ram_rdata <= '0;
    end else if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
      else          ram_rdata <= ram[o_mem_addr];
    end
  end
  assign i_mem_rdata = ram_rdata;

  task automatic adv;
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse_screenend;
    i_screenend = 1'b1;
    adv();
    i_screenend = 1'b0;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; ram_clr = 1'b1;
    i_animate = 0; i_screenend = 0; i_rd_req = 0; i_rd_addr = '0;
    i_wr_valid = 0; i_wr_addr = '0; i_wr_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    n_tests++;
    if ({o_rd_valid, o_drain_done, o_late, o_wr_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL reset_flags: got %b exp 0001", {o_rd_valid, o_drain_done, o_late, o_wr_ready});
    end
    n_tests++;
    if (o_frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_frame_cnt: got %0d exp 0", o_frame_cnt);
    end
    n_tests++;
    if ({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== 11'd0) begin
      n_fail++; $display("FAIL reset_mem: got %h exp 000", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata});
    end
    i_rst_n = 1'b1; ram_clr = 1'b0;
  endtask

  task automatic test_scan_drain;
    for (int k = 1; k <= 3; k++) begin
      i_wr_valid = 1; i_wr_addr = AW'(k); i_wr_data = DW'(k + 4);
      @(negedge i_clk);
      n_tests++;
      if ({o_wr_ready, o_mem_en} !== 2'b10) begin
        n_fail++; $display("FAIL scan_queue%0d: ready/en got %b exp 10", k, {o_wr_ready, o_mem_en});
      end
      adv();
    end
    i_wr_valid = 0; i_animate = 1;
    @(negedge i_clk);
    n_tests++;
    if (o_mem_en !== 1'b0) begin
      n_fail++; $display("FAIL scan_no_write: mem_en got %b exp 0", o_mem_en);
    end
    adv();
    i_animate = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_drain_done, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b0, 1'b1, 1'b1, AW'(j + 1), DW'(j + 5)}) begin
        n_fail++; $display("FAIL drain_write%0d: got done/en/we/a/d %b %b %b %0d %0d exp 0 1 1 %0d %0d",
                           j, o_drain_done, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, j + 1, j + 5);
      end
      adv();
    end
    @(negedge i_clk);
    n_tests++;
    if ({o_drain_done, o_mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL drain_done_pulse: done/en got %b exp 10", {o_drain_done, o_mem_en});
    end
    adv();
    @(negedge i_clk);
    n_tests++;
    if ({o_drain_done, o_mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL drain_done_single: done/en got %b exp 00", {o_drain_done, o_mem_en});
    end
    adv();
    pulse_screenend();
    @(negedge i_clk);
    n_tests++;
    if (o_frame_cnt !== 8'd1) begin
      n_fail++; $display("FAIL frame_cnt_1: got %0d exp 1", o_frame_cnt);
    end
    adv();
  endtask

  task automatic test_full;
    for (int k = 0; k < 4; k++) begin
      i_wr_valid = 1; i_wr_addr = AW'(10 + k); i_wr_data = DW'(k + 1);
      @(negedge i_clk);
      n_tests++;
      if (o_wr_ready !== 1'b1) begin
        n_fail++; $display("FAIL full_accept%0d: ready got %b exp 1", k, o_wr_ready);
      end
      adv();
    end
    i_wr_addr = AW'(14); i_wr_data = DW'(5);
    @(negedge i_clk);
    n_tests++;
    if ({o_wr_ready, o_mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL full_5th_blocked: ready/en got %b exp 00", {o_wr_ready, o_mem_en});
    end
    adv();
    i_animate = 1;
    adv();
    i_animate = 0;
    @(negedge i_clk);
    n_tests++;
    if ({o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b0, 1'b1, 1'b1, AW'(10), DW'(1)}) begin
      n_fail++; $display("FAIL full_first_pop: got r/en/we/a/d %b %b %b %0d %0d exp 0 1 1 10 1",
                         o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata);
    end
    adv();
    @(negedge i_clk);
    n_tests++;
    if ({o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b1, 1'b1, 1'b1, AW'(11), DW'(2)}) begin
      n_fail++; $display("FAIL full_push_pop: got r/en/we/a/d %b %b %b %0d %0d exp 1 1 1 11 2",
                         o_wr_ready, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata);
    end
    adv();
    i_wr_valid = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b1, 1'b1, AW'(12 + j), DW'(3 + j)}) begin
        n_fail++; $display("FAIL full_drain%0d: got a/d %0d %0d exp %0d %0d", j, o_mem_addr, o_mem_wdata, 12 + j, 3 + j);
      end
      adv();
    end
    @(negedge i_clk);
    n_tests++;
    if (o_drain_done !== 1'b1) begin
      n_fail++; $display("FAIL full_drain_done: got %b exp 1", o_drain_done);
    end
    adv();
    pulse_screenend();
    @(negedge i_clk);
    n_tests++;
    if (o_frame_cnt !== 8'd2) begin
      n_fail++; $display("FAIL frame_cnt_2: got %0d exp 2", o_frame_cnt);
    end
    adv();
  endtask

  task automatic test_read;
    i_wr_valid = 1; i_wr_addr = AW'(20); i_wr_data = DW'(8);
    adv();
    i_wr_addr = AW'(21); i_wr_data = DW'(9);
    adv();
    i_wr_valid = 0; i_animate = 1;
    adv();
    i_animate = 0; i_rd_req = 1; i_rd_addr = AW'(9);
    for (int j = 0; j < 3; j++) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_mem_en, o_mem_we, o_mem_addr, o_rd_valid} !== {1'b1, 1'b0, AW'(9), (j != 0)}) begin
        n_fail++; $display("FAIL read_win%0d: en/we/a/valid got %b %b %0d %b exp 1 0 9 %b",
                           j, o_mem_en, o_mem_we, o_mem_addr, o_rd_valid, (j != 0));
      end
      if (j != 0) begin
        n_tests++;
        if (o_rd_data !== DW'(9)) begin
          n_fail++; $display("FAIL read_data%0d: got %0d exp 9", j, o_rd_data);
        end
      end
      adv();
    end
    i_rd_req = 0;
    @(negedge i_clk);
    n_tests++;
    if ({o_rd_valid, o_rd_data, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b1, DW'(9), 1'b1, 1'b1, AW'(20), DW'(8)}) begin
      n_fail++; $display("FAIL read_resume: v/d en/we/a/d got %b %0d %b %b %0d %0d exp 1 9 1 1 20 8",
                         o_rd_valid, o_rd_data, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata);
    end
    adv();
    @(negedge i_clk);
    n_tests++;
    if ({o_rd_valid, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b0, 1'b1, AW'(21), DW'(9)}) begin
      n_fail++; $display("FAIL read_second_write: v/we/a/d got %b %b %0d %0d exp 0 1 21 9",
                         o_rd_valid, o_mem_we, o_mem_addr, o_mem_wdata);
    end
    adv();
    i_rd_req = 1; i_rd_addr = AW'(2);
    @(negedge i_clk);
    n_tests++;
    if ({o_drain_done, o_mem_en, o_mem_we} !== 3'b110) begin
      n_fail++; $display("FAIL read_done_state: done/en/we got %b exp 110", {o_drain_done, o_mem_en, o_mem_we});
    end
    adv();
    i_rd_addr = AW'(21);
    @(negedge i_clk);
    n_tests++;
    if ({o_rd_valid, o_rd_data} !== {1'b1, DW'(6)}) begin
      n_fail++; $display("FAIL read_back_addr2: v/d got %b %0d exp 1 6", o_rd_valid, o_rd_data);
    end
    adv();
    i_rd_req = 0;
    @(negedge i_clk);
    n_tests++;
    if ({o_rd_valid, o_rd_data} !== {1'b1, DW'(9)}) begin
      n_fail++; $display("FAIL read_back_addr21: v/d got %b %0d exp 1 9", o_rd_valid, o_rd_data);
    end
    adv();
    pulse_screenend();
  endtask

  task automatic test_late;
    for (int k = 0; k < 4; k++) begin
      i_wr_valid = 1; i_wr_addr = AW'(24 + k); i_wr_data = DW'(k + 1);
      adv();
    end
    i_wr_valid = 0; i_animate = 1; i_rd_req = 1; i_rd_addr = AW'(0);
    adv();
    i_animate = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_mem_en, o_mem_we, o_late} !== 3'b100) begin
        n_fail++; $display("FAIL late_hold%0d: en/we/late got %b exp 100", j, {o_mem_en, o_mem_we, o_late});
      end
      adv();
    end
    pulse_screenend();
    i_rd_req = 0;
    @(negedge i_clk);
    n_tests++;
    if ({o_late, o_mem_en, o_wr_ready, o_drain_done} !== 4'b1000) begin
      n_fail++; $display("FAIL late_pulse: late/en/ready/done got %b exp 1000", {o_late, o_mem_en, o_wr_ready, o_drain_done});
    end
    n_tests++;
    if (o_frame_cnt !== 8'd4) begin
      n_fail++; $display("FAIL frame_cnt_4: got %0d exp 4", o_frame_cnt);
    end
    adv();
    i_animate = 1;
    @(negedge i_clk);
    n_tests++;
    if ({o_late, o_mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL late_single: late/en got %b exp 00", {o_late, o_mem_en});
    end
    adv();
    i_animate = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b1, 1'b1, AW'(24 + j), DW'(j + 1)}) begin
        n_fail++; $display("FAIL late_redrain%0d: got a/d %0d %0d exp %0d %0d", j, o_mem_addr, o_mem_wdata, 24 + j, j + 1);
      end
      adv();
    end
    @(negedge i_clk);
    n_tests++;
    if (o_drain_done !== 1'b1) begin
      n_fail++; $display("FAIL late_redrain_done: got %b exp 1", o_drain_done);
    end
    adv();
    pulse_screenend();
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      i_wr_valid = 1; i_wr_addr = AW'(28 + k); i_wr_data = DW'(3 + k);
      adv();
    end
    i_wr_valid = 0; i_animate = 1;
    adv();
    i_animate = 0;
    @(negedge i_clk);
    n_tests++;
    if ({o_mem_we, o_mem_addr} !== {1'b1, AW'(28)}) begin
      n_fail++; $display("FAIL rstmid_pop: we/a got %b %0d exp 1 28", o_mem_we, o_mem_addr);
    end
    adv();
    i_rd_req = 1; i_rd_addr = AW'(7);
    adv();
    n_tests++;
    if (o_rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_inflight: rd_valid got %b exp 1", o_rd_valid);
    end
    i_rd_req = 0; i_rst_n = 0;
    #1;
    n_tests++;
    if ({o_rd_valid, o_drain_done, o_late, o_wr_ready, o_frame_cnt} !== {4'b0001, 8'd0}) begin
      n_fail++; $display("FAIL rstmid_regs: v/done/late/ready/cnt got %b %b %b %b %0d exp 0 0 0 1 0",
                         o_rd_valid, o_drain_done, o_late, o_wr_ready, o_frame_cnt);
    end
    n_tests++;
    if ({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== 11'd0) begin
      n_fail++; $display("FAIL rstmid_mem: got %h exp 000", {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata});
    end
    adv();
    i_rst_n = 1; i_animate = 1;
    adv();
    i_animate = 0;
    @(negedge i_clk);
    n_tests++;
    if ({o_mem_en, o_drain_done} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_flushed: en/done got %b exp 00", {o_mem_en, o_drain_done});
    end
    adv();
    @(negedge i_clk);
    n_tests++;
    if ({o_mem_en, o_drain_done, o_wr_ready} !== 3'b011) begin
      n_fail++; $display("FAIL rstmid_empty_done: en/done/ready got %b exp 011", {o_mem_en, o_drain_done, o_wr_ready});
    end
    adv();
  endtask

  task automatic test_frame_wrap;
    pulse_screenend();
    i_wr_valid = 1; i_wr_addr = AW'(31); i_wr_data = DW'(15);
    adv();
    i_wr_valid = 0; i_animate = 1; i_screenend = 1;
    adv();
    i_animate = 0; i_screenend = 0;
    @(negedge i_clk);
    n_tests++;
    if ({o_mem_en, o_frame_cnt} !== {1'b0, 8'd2}) begin
      n_fail++; $display("FAIL screenend_wins: en/cnt got %b %0d exp 0 2", o_mem_en, o_frame_cnt);
    end
    adv();
    i_animate = 1;
    adv();
    i_animate = 0;
    @(negedge i_clk);
    n_tests++;
    if ({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata} !== {1'b1, 1'b1, AW'(31), DW'(15)}) begin
      n_fail++; $display("FAIL wrap_write: a/d got %0d %0d exp 31 15", o_mem_addr, o_mem_wdata);
    end
    adv();
    for (int k = 0; k < 253; k++) begin
      pulse_screenend();
      adv();
    end
    @(negedge i_clk);
    n_tests++;
    if (o_frame_cnt !== 8'd255) begin
      n_fail++; $display("FAIL frame_cnt_255: got %0d exp 255", o_frame_cnt);
    end
    adv();
    pulse_screenend();
    @(negedge i_clk);
    n_tests++;
    if (o_frame_cnt !== 8'd0) begin
      n_fail++; $display("FAIL frame_cnt_wrap: got %0d exp 0", o_frame_cnt);
    end
    adv();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_scan_drain();
    test_full();
    test_read();
    test_late();
    test_reset_mid();
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
